neo_instr_sender: RTL and testbench
===================================

Name: neo_instr_sender

Overview:
- Upstream feeder for the FPGA-side Neo GPIO bridge.
- Takes a full-width instruction from the host/controller on a valid/ready interface and splits it into 32-bit chunks.
- Delivers each chunk to the Neo chip over the 4-phase instruction_req / instruction_ack handshake, with ack synchronization and timeout detection.

Parameters:
- INSTR_WIDTH, 128, width of one full instruction; must be an integer multiple of CHUNK_WIDTH.
- CHUNK_WIDTH, 32, width of one chunk on the instruction bus.
- SYNC_STAGES, 2, flops in the instruction_ack synchronizer (minimum 2).
- TIMEOUT_CYC, 1024, clk cycles allowed in either ack-wait state before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- instr_valid  in  1  host offers an instruction
- instr_data  in  INSTR_WIDTH  instruction word
- instr_ready  out  1  sender idle, can accept an instruction
- instruction_req  out  1  4-phase request toward the chip
- instruction_chunked  out  CHUNK_WIDTH  current chunk
- instruction_ack  in  1  4-phase ack from the chip (asynchronous to clk)
- busy  out  1  transfer in progress
- chunk_idx  out  $clog2(NUM_CHUNKS)+1  index of the chunk currently on the bus
- timeout_err  out  1  sticky abort flag
- err_clr  in  1  one-cycle pulse that clears timeout_err

Behaviour:
- NUM_CHUNKS = INSTR_WIDTH/CHUNK_WIDTH.
- Chunks are sent LSB chunk first: chunk k = instr_data[k*CW +: CW].
- The instruction is latched into an internal shift register on the accept cycle.
- Ack path: instruction_ack passes through SYNC_STAGES flops to produce ack_s. Only ack_s is used internally.
- Reset (rst=0, asynchronous):
  - state = IDLE; instruction_req = 0; instruction_chunked = 0; chunk_idx = 0; busy = 0; timeout_err = 0; instr_ready = 1; synchronizer flops = 0.
  - Reset mid-transfer drops req immediately and discards the instruction.
- States and transitions:
  - IDLE: instr_ready = 1. Accept when instr_valid & instr_ready, then go to SETUP.
  - SETUP: drive instruction_chunked = chunk[chunk_idx] with req = 0. Lasts exactly 1 cycle (data setup before req). Next state REQ_HI.
  - REQ_HI: req = 1. Wait for ack_s = 1, then go to REQ_LO. Req falls on the cycle after ack_s is seen high.
  - REQ_LO: req = 0. Wait for ack_s = 0. Then:
    - if chunk_idx = NUM_CHUNKS-1, go to IDLE;
    - otherwise increment chunk_idx and go to SETUP.
- instruction_chunked is held stable from SETUP through the end of REQ_LO. It changes only on entry to SETUP.
- instruction_chunked keeps its last value while IDLE.
- busy = 1 in every state except IDLE. instr_ready = ~busy & ~timeout_err.
- Ack already high at SETUP (stale ack): remain in SETUP until ack_s = 0, then proceed. The timeout counter runs during this wait.
- Timeout:
  - A counter is cleared on entry to REQ_HI, REQ_LO, or a stale-wait SETUP, and increments each cycle in those states.
  - When the counter reaches TIMEOUT_CYC-1 without the awaited ack_s level: set timeout_err, force req = 0, clear chunk_idx, go to IDLE. The remaining chunks are dropped.
- timeout_err is sticky and blocks instr_ready. err_clr clears it, taking effect the next cycle.
  - If err_clr and a new timeout occur in the same cycle, the timeout wins.
- Throughput: with the chip acking in 0 cycles, one chunk costs 1 + (SYNC_STAGES+1) + (SYNC_STAGES+1) cycles. That is 7 cycles per chunk at the default SYNC_STAGES.
- A new instruction is never accepted on the cycle the last handshake completes. instr_ready rises the cycle after returning to IDLE.

Test Plan:
- Reset, then instr_valid with instr_data = 128'h4444_4444_3333_3333_2222_2222_1111_1111 and an immediate-ack responder -> chunks 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444 in order; each chunk is stable whenever req=1; instr_ready returns 1 after the 4th ack falls.
- Responder with ack delayed by 5 cycles in both phases -> no req edge occurs before the matching ack_s edge; chunk_idx steps 0→3; busy stays 1 throughout.
- Responder never asserts ack, TIMEOUT_CYC = 16 -> req drops 16 cycles after entering REQ_HI; timeout_err = 1; instr_ready = 0 until err_clr is pulsed, then 1 one cycle later.
- Ack held high before the transfer starts -> the block stays in SETUP with req = 0 until ack is released, then the normal handshake follows.
- rst asserted low while in REQ_HI on chunk 2 -> req = 0 and instruction_chunked = 0 immediately, with no clock edge needed; after release, a fresh instruction transfers from chunk 0.
- instr_valid held high across back-to-back instructions A and B -> B is accepted exactly once, only after A's 4th handshake completes; no chunk is duplicated or skipped.

Source files
------------

// File: rtl/neo_instr_sender.sv
// Splits a wide instruction into CHUNK_WIDTH chunks (LSB first); each goes out over a 4-phase req/ack handshake.
// 1 + 2*(SYNC_STAGES+1) cycles per chunk with a zero-delay ack; instr_ready stays low while busy or after a timeout.
module neo_instr_sender #(
  parameter int INSTR_WIDTH = 128,
  parameter int CHUNK_WIDTH = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        instr_valid,
  input  logic [INSTR_WIDTH-1:0]                      instr_data,
  output logic                                        instr_ready,
  output logic                                        instruction_req,
  output logic [CHUNK_WIDTH-1:0]                      instruction_chunked,
  input  logic                                        instruction_ack,
  output logic                                        busy,
  output logic [$clog2(INSTR_WIDTH/CHUNK_WIDTH):0]    chunk_idx,
  output logic                                        timeout_err,
  input  logic                                        err_clr
);

  localparam int NUM_CHUNKS = INSTR_WIDTH / CHUNK_WIDTH;
  localparam int IDX_W      = $clog2(NUM_CHUNKS) + 1;
  localparam int CNT_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, REQ_HI, REQ_LO} state_t;

  state_t                   state, state_nxt;
  logic [SYNC_STAGES-1:0]   ack_sync;
  logic                     ack_s;
  logic [INSTR_WIDTH-1:0]   shreg;
  logic [CNT_W-1:0]         wait_cnt;
  logic                     accept, chunk_done, tmo_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ack_sync <= '0;
    else      ack_sync <= {ack_sync[SYNC_STAGES-2:0], instruction_ack};
  end
  assign ack_s = ack_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    accept          = 1'b0;
    chunk_done      = 1'b0;
    tmo_hit         = 1'b0;
    busy            = (state != IDLE);
    instruction_req = (state == REQ_HI);
    instr_ready     = ~busy & ~timeout_err;
    case (state)
      IDLE: begin
        if (instr_valid && instr_ready) begin
          accept    = 1'b1;
          state_nxt = SETUP;
        end
      end
      // A stale ack still high from the chip holds us here before raising req.
      SETUP: begin
        if (!ack_s)                   state_nxt = REQ_HI;
        else if (wait_cnt == CNT_MAX) tmo_hit   = 1'b1;
      end
      REQ_HI: begin
        if (ack_s)                    state_nxt = REQ_LO;
        else if (wait_cnt == CNT_MAX) tmo_hit   = 1'b1;
      end
      REQ_LO: begin
        if (!ack_s) begin
          chunk_done = 1'b1;
          state_nxt  = (chunk_idx == LAST_IDX) ? IDLE : SETUP;
        end else if (wait_cnt == CNT_MAX) begin
          tmo_hit = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (tmo_hit) state_nxt = IDLE;
  end

  // Restarts on every state entry so each wait gets the full budget.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    wait_cnt <= '0;
    else if (state == IDLE || state_nxt != state) wait_cnt <= '0;
    else                                         wait_cnt <= wait_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg               <= '0;
      instruction_chunked <= '0;
      chunk_idx           <= '0;
      timeout_err         <= 1'b0;
    end else begin
      if (accept) begin
        instruction_chunked <= instr_data[CHUNK_WIDTH-1:0];
        shreg               <= instr_data >> CHUNK_WIDTH;
        chunk_idx           <= '0;
      end else if (chunk_done && chunk_idx != LAST_IDX) begin
        instruction_chunked <= shreg[CHUNK_WIDTH-1:0];
        shreg               <= shreg >> CHUNK_WIDTH;
        chunk_idx           <= chunk_idx + IDX_W'(1);
      end else if (chunk_done || tmo_hit) begin
        chunk_idx <= '0;
      end

      if (tmo_hit)      timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_neo_instr_sender.sv
// Directed bench for neo_instr_sender: a chip responder with programmable ack delay plus a
// chunk-queue model of the transfer, checked on every negedge.
module tb_neo_instr_sender;

  localparam int IW = 128;
  localparam int CW = 32;
  localparam int SS = 2;
  localparam int TO = 16;
  localparam int NC = IW / CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_valid;
  logic [IW-1:0] instr_data;
  logic          instr_ready;
  logic          instruction_req;
  logic [CW-1:0] instruction_chunked;
  logic          instruction_ack;
  logic          busy;
  logic [2:0]    chunk_idx;
  logic          timeout_err;
  logic          err_clr;

  neo_instr_sender #(
    .INSTR_WIDTH(IW), .CHUNK_WIDTH(CW), .SYNC_STAGES(SS), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_ready(instr_ready),
    .instruction_req(instruction_req), .instruction_chunked(instruction_chunked),
    .instruction_ack(instruction_ack), .busy(busy), .chunk_idx(chunk_idx),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Model: chunks still owed to the chip, in send order.
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] cur_exp;
  int            exp_idx;
  logic [SS-1:0] ack_hist;
  logic          prev_ack_s, prev_req, prev_ready, prev_err;
  logic [CW-1:0] prev_chunked;
  int            n_accept, n_falls, falls_mark, falls_gap;
  logic [CW-1:0] obs_dat[$];
  int            obs_idx[$];

  // Chip responder controls.
  logic resp_en, resp_force;
  int   resp_dly, resp_cnt;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_step();
    logic ack_s_now;
    if (!rst) begin
      exp_q.delete();
      ack_hist     = '0;
      prev_ack_s   = 1'b0;
      prev_req     = 1'b0;
      prev_ready   = 1'b1;
      prev_err     = 1'b0;
      prev_chunked = '0;
      return;
    end
    ack_hist  = {ack_hist[SS-2:0], instruction_ack};
    ack_s_now = ack_hist[SS-1];

    if (timeout_err && !prev_err) exp_q.delete();
    if (instr_valid && prev_ready) begin
      falls_gap  = n_falls - falls_mark;
      falls_mark = n_falls;
      n_accept++;
      for (int k = 0; k < NC; k++) exp_q.push_back(instr_data[k*CW +: CW]);
      exp_idx = 0;
    end

    chk("ready_rule", instr_ready, !busy && !timeout_err);
    if (exp_q.size() != 0) chk("busy_pending", busy, 1'b1);

    if (instruction_req && !prev_req) begin
      chk("rise_after_ack_s_low", prev_ack_s, 1'b0);
      chk("data_setup_before_req", instruction_chunked, prev_chunked);
      chk("chunk_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        cur_exp = exp_q.pop_front();
        chk("chunk_dat", instruction_chunked, cur_exp);
        chk("chunk_idx", chunk_idx, exp_idx);
        obs_dat.push_back(instruction_chunked);
        obs_idx.push_back(int'(chunk_idx));
        exp_idx++;
      end
    end else if (instruction_req) begin
      chk("chunk_stable_under_req", instruction_chunked, cur_exp);
    end

    if (!instruction_req && prev_req) begin
      n_falls++;
      if (!(timeout_err && !prev_err)) chk("fall_after_ack_s_high", prev_ack_s, 1'b1);
    end

    prev_ack_s   = ack_s_now;
    prev_req     = instruction_req;
    prev_ready   = instr_ready;
    prev_err     = timeout_err;
    prev_chunked = instruction_chunked;
  endtask

  // One cycle: sample at negedge, then drive the chip ack just after it.
  task automatic step();
    @(negedge clk);
    model_step();
    #1;
    if (!resp_en) begin
      instruction_ack = resp_force;
    end else if (instruction_req != instruction_ack) begin
      if (resp_cnt >= resp_dly) begin
        instruction_ack = instruction_req;
        resp_cnt = 0;
      end else begin
        resp_cnt++;
      end
    end else begin
      resp_cnt = 0;
    end
  endtask

  task automatic send(input logic [IW-1:0] d);
    int a0;
    int t;
    a0 = n_accept;
    t  = 0;
    instr_valid = 1'b1;
    instr_data  = d;
    while (n_accept == a0 && t < 200) begin
      step();
      t++;
    end
    chk("accepted", n_accept - a0, 1);
    instr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    while (busy && n < budget) begin
      n++;
      step();
    end
    chk("idle_within_budget", busy, 1'b0);
  endtask

  task automatic chk_obs(input string name, input int base,
                         input logic [CW-1:0] e0, e1, e2, e3);
    logic [CW-1:0] e [4];
    e = '{e0, e1, e2, e3};
    for (int k = 0; k < 4; k++) begin
      if (base + k < obs_dat.size()) begin
        chk(name, obs_dat[base+k], e[k]);
        chk({name, "_idx"}, obs_idx[base+k], k);
      end else begin
        chk({name, "_missing"}, obs_dat.size(), base + k + 1);
      end
    end
  endtask

  initial begin
    int n;
    int t;
    int a0;
    logic seen;

    rst = 1'b0; instr_valid = 1'b0; instr_data = '0; err_clr = 1'b0;
    instruction_ack = 1'b0; resp_en = 1'b1; resp_force = 1'b0; resp_dly = 0; resp_cnt = 0;
    n_accept = 0; n_falls = 0; falls_mark = 0; falls_gap = 0; exp_idx = 0; cur_exp = '0;
    ack_hist = '0; prev_ack_s = 1'b0; prev_req = 1'b0; prev_ready = 1'b1; prev_err = 1'b0;
    prev_chunked = '0;

    // Reset state
    step(); step();
    chk("rst_req", instruction_req, 1'b0);
    chk("rst_chunk", instruction_chunked, 32'h0);
    chk("rst_idx", chunk_idx, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", timeout_err, 1'b0);
    chk("rst_ready", instr_ready, 1'b1);
    rst = 1'b1;
    step(); step();

    // 1: immediate ack, 7 cycles per chunk -> 28 busy cycles
    obs_dat.delete(); obs_idx.delete();
    resp_en = 1'b1; resp_dly = 0;
    send(128'h4444_4444_3333_3333_2222_2222_1111_1111);
    wait_idle(200, n);
    chk("imm_busy_cycles", n, 28);
    chk_obs("imm_chunk", 0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);
    chk("imm_count", obs_dat.size(), 4);
    chk("imm_ready_back", instr_ready, 1'b1);
    step(); step();

    // 2: ack delayed 5 cycles in both phases
    obs_dat.delete(); obs_idx.delete();
    resp_dly = 5;
    send({32'hD0D0_0003, 32'hD0D0_0002, 32'hD0D0_0001, 32'hD0D0_0000});
    wait_idle(400, n);
    chk("dly_handshakes_before_idle", n_falls - falls_mark, 4);
    chk_obs("dly_chunk", 0, 32'hD0D0_0000, 32'hD0D0_0001, 32'hD0D0_0002, 32'hD0D0_0003);
    chk("dly_count", obs_dat.size(), 4);
    step(); step();

    // 3: chip never acks -> timeout after 16 cycles of req
    obs_dat.delete(); obs_idx.delete();
    resp_en = 1'b0; resp_force = 1'b0;
    send({32'h7777_0004, 32'h7777_0003, 32'h7777_0002, 32'h7777_0001});
    t = 0;
    while (!instruction_req && t < 50) begin
      step();
      t++;
    end
    chk("tmo_req_seen", instruction_req, 1'b1);
    n = 0;
    while (instruction_req && n < 100) begin
      n++;
      step();
    end
    chk("tmo_req_cycles", n, 16);
    chk("tmo_err_set", timeout_err, 1'b1);
    chk("tmo_ready_low", instr_ready, 1'b0);
    chk("tmo_busy_low", busy, 1'b0);
    chk("tmo_idx_cleared", chunk_idx, 3'd0);
    step(); step(); step();
    chk("tmo_err_sticky", timeout_err, 1'b1);
    chk("tmo_ready_blocked", instr_ready, 1'b0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_err", timeout_err, 1'b0);
    chk("clr_ready", instr_ready, 1'b1);
    chk("tmo_chunks_sent", obs_dat.size(), 1);
    step(); step();

    // 4: stale ack high before the transfer
    obs_dat.delete(); obs_idx.delete();
    resp_en = 1'b0; resp_force = 1'b1;
    step(); step(); step(); step();
    send({32'h5A5A_0004, 32'h5A5A_0003, 32'h5A5A_0002, 32'h5A5A_0001});
    for (int i = 0; i < 6; i++) begin
      step();
      chk("stale_req_low", instruction_req, 1'b0);
      chk("stale_busy", busy, 1'b1);
    end
    resp_dly = 0; resp_en = 1'b1;
    wait_idle(200, n);
    chk_obs("stale_chunk", 0, 32'h5A5A_0001, 32'h5A5A_0002, 32'h5A5A_0003, 32'h5A5A_0004);
    chk("stale_err", timeout_err, 1'b0);
    step(); step();

    // 5: asynchronous reset while in REQ_HI on chunk 2
    obs_dat.delete(); obs_idx.delete();
    resp_dly = 2;
    send({32'hEEEE_0003, 32'hEEEE_0002, 32'hEEEE_0001, 32'hEEEE_0000});
    seen = 1'b0;
    t = 0;
    while (!seen && t < 300) begin
      step();
      t++;
      seen = instruction_req && chunk_idx == 3'd2;
    end
    chk("rst_mid_reached_chunk2", seen, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("arst_req", instruction_req, 1'b0);
    chk("arst_chunk", instruction_chunked, 32'h0);
    chk("arst_idx", chunk_idx, 3'd0);
    chk("arst_busy", busy, 1'b0);
    step(); step();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step();
    obs_dat.delete(); obs_idx.delete();
    resp_dly = 0;
    send({32'hF00D_0003, 32'hF00D_0002, 32'hF00D_0001, 32'hF00D_0000});
    wait_idle(200, n);
    chk_obs("post_rst_chunk", 0, 32'hF00D_0000, 32'hF00D_0001, 32'hF00D_0002, 32'hF00D_0003);
    chk("post_rst_count", obs_dat.size(), 4);
    step(); step();

    // 6: instr_valid held across back-to-back A and B
    obs_dat.delete(); obs_idx.delete();
    a0 = n_accept;
    instr_valid = 1'b1;
    instr_data  = {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000};
    t = 0;
    while (n_accept == a0 && t < 50) begin
      step();
      t++;
    end
    chk("b2b_a_accepted", n_accept - a0, 1);
    instr_data = {32'hBBBB_0003, 32'hBBBB_0002, 32'hBBBB_0001, 32'hBBBB_0000};
    t = 0;
    while (n_accept == a0 + 1 && t < 300) begin
      step();
      t++;
    end
    chk("b2b_b_accepted", n_accept - a0, 2);
    chk("b2b_b_after_4_handshakes", falls_gap, 4);
    instr_valid = 1'b0;
    wait_idle(200, n);
    for (int i = 0; i < 20; i++) step();
    chk("b2b_accept_once", n_accept - a0, 2);
    chk("b2b_count", obs_dat.size(), 8);
    chk_obs("b2b_a_chunk", 0, 32'hAAAA_0000, 32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003);
    chk_obs("b2b_b_chunk", 4, 32'hBBBB_0000, 32'hBBBB_0001, 32'hBBBB_0002, 32'hBBBB_0003);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
